// File: rtl/noc_packet_injector_pkg.sv
// Shared definitions for the NoC packet injector: flit width, header field layout and FSM states.
// The Noc_parameters.v macro is carried here so every file sees one flit width.
`ifndef NOC_PARAMETERS_V
`define NOC_PARAMETERS_V
`define Noc_Data_Width 32
`endif

package noc_packet_injector_pkg;

    localparam int DW = `Noc_Data_Width;

    // Header layout: destination in the top byte, source node in the next byte, rest zero.
    localparam int HDR_DEST_HI = DW - 1;
    localparam int HDR_DEST_LO = DW - 8;
    localparam int HDR_SRC_HI  = DW - 9;
    localparam int HDR_SRC_LO  = DW - 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } inj_state_t;

    function automatic logic [DW-1:0] make_header(input logic [7:0] dest, input logic [7:0] src);
        logic [DW-1:0] hdr;
        hdr = '0;
        hdr[HDR_DEST_HI:HDR_DEST_LO] = dest;
        hdr[HDR_SRC_HI:HDR_SRC_LO]   = src;
        return hdr;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through payload buffer; the head entry is visible on rd_data whenever empty is low.
module noc_flit_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Turns a stream of local payload words into header + body flits for a router receive port.
// Valid/ready: a transfer happens on any rising edge where both valid and ready are high.
module noc_packet_injector
    import noc_packet_injector_pkg::*;
#(
    parameter logic [7:0] NODE_ID    = 8'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic          noc_clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [7:0]    in_dest,
    input  logic          in_last,
    output logic          Noc_send_valid,
    input  logic          Noc_send_ready,
    output logic [DW-1:0] Noc_send_flit,
    input  logic          Noc_send_VCready,
    output logic          Noc_send_is_header,
    output logic          Noc_send_is_tail,
    output logic [15:0]   sent_pkt_cnt
);

    localparam int EW = DW + 9;

    inj_state_t    state;
    inj_state_t    state_next;
    logic          ready_en;
    logic          first_word;
    logic [7:0]    pkt_dest;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;
    logic [7:0]    head_dest;
    logic          head_last;
    logic [DW-1:0] head_data;

    assign in_ready = ready_en && !fifo_full;
    assign push     = in_valid && in_ready;
    // Later words of a packet reuse the destination captured on its first word.
    assign wr_entry = {(first_word ? in_dest : pkt_dest), in_last, in_data};
    assign {head_dest, head_last, head_data} = head_entry;

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            first_word <= 1'b1;
            pkt_dest   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                first_word <= in_last;
                if (first_word) pkt_dest <= in_dest;
            end
        end
    end

    noc_flit_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (noc_clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sent_pkt_cnt <= '0;
        end else begin
            state <= state_next;
            if (pop && head_last) sent_pkt_cnt <= sent_pkt_cnt + 16'd1;
        end
    end

    always_comb begin
        state_next         = state;
        Noc_send_valid     = 1'b0;
        Noc_send_flit      = '0;
        Noc_send_is_header = 1'b0;
        Noc_send_is_tail   = 1'b0;
        pop                = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && Noc_send_VCready) state_next = ST_HEAD;
            end
            ST_HEAD: begin
                Noc_send_valid     = 1'b1;
                Noc_send_is_header = 1'b1;
                Noc_send_flit      = make_header(head_dest, NODE_ID);
                if (Noc_send_ready) state_next = ST_BODY;
            end
            ST_BODY: begin
                // The head entry only changes on a pop, so a presented flit holds until accepted.
                if (!fifo_empty) begin
                    Noc_send_valid   = 1'b1;
                    Noc_send_flit    = head_data;
                    Noc_send_is_tail = head_last;
                    if (Noc_send_ready) begin
                        pop = 1'b1;
                        if (head_last) state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector: packets are modelled as header + payload list, monitor pops and compares.
module tb_noc_packet_injector;
    import noc_packet_injector_pkg::*;

    localparam logic [7:0] NODE = 8'h01;

    logic          noc_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [7:0]    in_dest = '0;
    logic          in_last = 1'b0;
    logic          Noc_send_valid;
    logic          Noc_send_ready = 1'b0;
    logic [DW-1:0] Noc_send_flit;
    logic          Noc_send_VCready = 1'b0;
    logic          Noc_send_is_header;
    logic          Noc_send_is_tail;
    logic [15:0]   sent_pkt_cnt;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW+1:0] exp_q[$];
    int            exp_cnt = 0;
    int            ready_mode = 1;
    int            vc_mode = 1;
    logic [DW-1:0] last_hdr = '0;
    logic [DW-1:0] pkt_w [16];
    int            pkt_len = 0;
    logic [7:0]    pkt_dest = '0;
    logic          stalled = 1'b0;
    logic [DW+1:0] prev_flit = '0;
    logic [DW+1:0] mon_act;
    logic [DW+1:0] mon_exp;

    noc_packet_injector #(
        .NODE_ID    (NODE),
        .FIFO_DEPTH (4)
    ) dut (
        .noc_clk            (noc_clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_dest            (in_dest),
        .in_last            (in_last),
        .Noc_send_valid     (Noc_send_valid),
        .Noc_send_ready     (Noc_send_ready),
        .Noc_send_flit      (Noc_send_flit),
        .Noc_send_VCready   (Noc_send_VCready),
        .Noc_send_is_header (Noc_send_is_header),
        .Noc_send_is_tail   (Noc_send_is_tail),
        .sent_pkt_cnt       (sent_pkt_cnt)
    );

    // ---------------- clock / router-side drivers ----------------
    always #5 noc_clk = ~noc_clk;

    always @(posedge noc_clk) begin
        #1;
        case (ready_mode)
            0:       Noc_send_ready = 1'b0;
            1:       Noc_send_ready = 1'b1;
            default: Noc_send_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (vc_mode)
            0:       Noc_send_VCready = 1'b0;
            1:       Noc_send_VCready = 1'b1;
            default: Noc_send_VCready = ($urandom_range(0, 1) == 1);
        endcase
    end

    task automatic check(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge noc_clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            mon_act = {Noc_send_is_header, Noc_send_is_tail, Noc_send_flit};
            if (stalled) begin
                check("hold_valid", Noc_send_valid, 1);
                check("hold_flit", mon_act, prev_flit);
            end
            if (Noc_send_valid) check("hdr_tail_excl", Noc_send_is_header & Noc_send_is_tail, 0);
            if (Noc_send_valid && Noc_send_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_flit: got %h expected none at %0t", mon_act, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("flit", mon_act, mon_exp);
                end
                if (Noc_send_is_header) last_hdr = Noc_send_flit;
            end
            stalled   = Noc_send_valid && !Noc_send_ready;
            prev_flit = mon_act;
        end
    end

    // ---------------- reference model and local-side drivers ----------------
    task automatic gen_packet(input logic [7:0] dest, input int len, input logic fixed,
                              input logic [DW-1:0] w0);
        pkt_dest = dest;
        pkt_len  = len;
        exp_q.push_back({1'b1, 1'b0, dest, NODE, {(DW-16){1'b0}}});
        for (int i = 0; i < len; i++) begin
            pkt_w[i] = (fixed && i == 0) ? w0 : DW'($urandom);
            exp_q.push_back({1'b0, (i == len - 1), pkt_w[i]});
        end
        exp_cnt++;
    endtask

    task automatic align();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic drive_word(input int i);
        int n;
        in_data  = pkt_w[i];
        in_dest  = (i == 0) ? pkt_dest : 8'($urandom);
        in_last  = (i == pkt_len - 1);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge noc_clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", in_ready);
                break;
            end
        end
        align();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] dest, input int len, input logic gaps);
        gen_packet(dest, len, 1'b0, '0);
        for (int i = 0; i < len; i++) begin
            drive_word(i);
            if (gaps) repeat ($urandom_range(0, 2)) align();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge noc_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d flits outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge noc_clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", Noc_send_valid, 0);
        check("rst_flit", Noc_send_flit, 0);
        check("rst_hdr", Noc_send_is_header, 0);
        check("rst_tail", Noc_send_is_tail, 0);
        check("rst_cnt", sent_pkt_cnt, 0);
        @(negedge noc_clk);
        @(negedge noc_clk);
        #3 rst_n = 1'b1;
        #1 check("rel_in_ready_low", in_ready, 0);
        @(negedge noc_clk);
        check("rel_in_ready_high", in_ready, 1);

        // single-word packet
        align();
        gen_packet(8'h03, 1, 1'b1, DW'(32'h0000_00AA));
        drive_word(0);
        drain();
        check("single_hdr", last_hdr, {8'h03, 8'h01, {(DW-16){1'b0}}});
        check("single_cnt", sent_pkt_cnt, 1);

        // back-to-back packets with different destinations
        align();
        send_packet(8'h05, 3, 1'b0);
        send_packet(8'h09, 2, 1'b0);
        drain();
        check("b2b_last_dest", last_hdr[DW-1:DW-8], 8'h09);
        check("b2b_cnt", sent_pkt_cnt, exp_cnt[15:0]);

        // no virtual channel: packet must wait in IDLE
        @(negedge noc_clk);
        vc_mode = 0;
        align();
        send_packet(8'($urandom), 3, 1'b0);
        repeat (10) begin
            @(negedge noc_clk);
            check("vc_block_valid", Noc_send_valid, 0);
        end
        vc_mode = 1;
        @(negedge noc_clk);
        check("vc_rise_valid_low", Noc_send_valid, 0);
        @(negedge noc_clk);
        check("vc_next_hdr", {Noc_send_valid, Noc_send_is_header}, 2'b11);
        drain();
        check("vc_cnt", sent_pkt_cnt, exp_cnt[15:0]);

        // router stall on the second body flit
        @(negedge noc_clk);
        ready_mode = 0;
        align();
        send_packet(8'($urandom), 4, 1'b0);
        @(negedge noc_clk);
        ready_mode = 1;
        @(negedge noc_clk);
        @(negedge noc_clk);
        ready_mode = 0;
        @(negedge noc_clk);
        check("stall_body2", Noc_send_flit, pkt_w[1]);
        repeat (4) @(negedge noc_clk);
        ready_mode = 1;
        drain();
        check("stall_cnt", sent_pkt_cnt, exp_cnt[15:0]);

        // fill the buffer while the router refuses flits
        @(negedge noc_clk);
        ready_mode = 0;
        align();
        gen_packet(8'($urandom), 6, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive_word(i);
        @(negedge noc_clk);
        check("fill_ready_3", in_ready, 1);
        align();
        drive_word(3);
        @(negedge noc_clk);
        check("full_ready_low", in_ready, 0);
        ready_mode = 1;
        align();
        drive_word(4);
        drive_word(5);
        drain();
        check("full_cnt", sent_pkt_cnt, exp_cnt[15:0]);

        // randomized traffic with random router back-pressure and VC availability
        @(negedge noc_clk);
        ready_mode = 2;
        vc_mode = 2;
        align();
        for (int p = 0; p < 40; p++) begin
            send_packet(8'($urandom_range(0, 255)), $urandom_range(1, 6), 1'b1);
        end
        drain();
        check("rand_cnt", sent_pkt_cnt, exp_cnt[15:0]);

        // reset in the middle of a packet
        @(negedge noc_clk);
        ready_mode = 0;
        vc_mode = 1;
        align();
        send_packet(8'h44, 4, 1'b0);
        @(negedge noc_clk);
        ready_mode = 1;
        @(negedge noc_clk);
        ready_mode = 0;
        @(negedge noc_clk);
        check("pre_rst_body", {Noc_send_valid, Noc_send_is_header}, 2'b10);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check("mid_rst_valid", Noc_send_valid, 0);
        check("mid_rst_flit", Noc_send_flit, 0);
        check("mid_rst_hdr", Noc_send_is_header, 0);
        check("mid_rst_tail", Noc_send_is_tail, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_cnt", sent_pkt_cnt, 0);
        @(negedge noc_clk);
        #2 rst_n = 1'b1;
        #1 check("rerel_in_ready_low", in_ready, 0);
        @(negedge noc_clk);
        check("rerel_in_ready_high", in_ready, 1);
        ready_mode = 1;
        align();
        send_packet(8'h22, 2, 1'b0);
        drain();
        check("post_rst_cnt", sent_pkt_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
